// File: rtl/fetch_unit.sv
// fetch_unit: IF stage (PC in; imem req/gnt/rvalid out/in; redirect/id_stall in; IF/ID buffer if_* out; pc_en, fetch_err out)
module fetch_unit #(
  parameter logic [31:0] FLUSH_INSTR = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        fetch_err
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
  state_t      r_state;
  logic [31:0] r_pend, r_instr, r_pc, r_pc4;
  logic        r_valid, r_err;
  logic        w_mis, w_can_issue;
  always_comb begin
    w_mis       = ALIGN_CHECK && (PC[1:0] != 2'b00);
    w_can_issue = !r_valid || !id_stall;
    imem_req    = (r_state == S_REQ) && w_can_issue && !w_mis && !reset;
    imem_addr   = imem_req ? PC : 32'h0;
    pc_en       = (r_state == S_WAIT) && imem_rvalid && !redirect && !reset;
    if_valid    = r_valid;
    if_instr    = r_valid ? r_instr : FLUSH_INSTR;
    if_pc       = r_pc;
    if_pc4      = r_pc4;
    fetch_err   = r_err;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_REQ;
      r_valid <= 1'b0;
      r_instr <= FLUSH_INSTR;
      r_pc    <= 32'h0;
      r_pc4   <= 32'd4;
      r_err   <= 1'b0;
      r_pend  <= 32'h0;
    end else begin
      r_valid <= redirect ? 1'b0 : pc_en ? 1'b1 : id_stall ? r_valid : 1'b0;
      if (pc_en) begin
        r_instr <= imem_rdata;
        r_pc    <= r_pend;
        r_pc4   <= r_pend + 32'd4;
      end
      if (r_state == S_REQ && w_mis) r_err <= 1'b1;
      case (r_state)
        S_REQ: if (imem_req && imem_gnt) begin
          r_state <= redirect ? S_DROP : S_WAIT;
          r_pend  <= PC;
        end
        S_WAIT:  r_state <= imem_rvalid ? S_REQ : redirect ? S_DROP : S_WAIT;
        S_DROP:  r_state <= imem_rvalid ? S_REQ : S_DROP;
        default: r_state <= S_REQ;
      endcase
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the multistage pipeline; consumes the current PC and drives instruction memory over a req/gnt/rvalid handshake.
- Fills a single-entry IF/ID buffer for the decode stage.
- Returns a one-cycle pc_en pulse so the PC register loads NPC only when a fetch completes.
- Handles branch/jump redirects by discarding stale in-flight fetches.

Parameters:
FLUSH_INSTR, 32'h0000_0000, value driven on if_instr whenever if_valid=0 (MIPS nop).
ALIGN_CHECK, 1, 1 = word-alignment check on PC enabled; 0 = PC[1:0] ignored.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
PC  in  32  current fetch address from PC register.
pc_en  out  1  combinational; 1 = PC register loads NPC this edge.
imem_req  out  1  fetch request, held until imem_gnt.
imem_addr  out  32  fetch address (= PC while imem_req=1, else 0).
imem_gnt  in  1  memory accepted request this cycle.
imem_rvalid  in  1  response data valid (>=1 cycle after gnt).
imem_rdata  in  32  instruction word.
redirect  in  1  branch/jump taken; PC already carries target next cycle.
id_stall  in  1  decode cannot accept the buffered instruction.
if_valid  out  1  IF/ID buffer holds a valid instruction.
if_instr  out  32  buffered instruction (FLUSH_INSTR when invalid).
if_pc  out  32  address of buffered instruction.
if_pc4  out  32  if_pc + 4, modulo 2^32.
fetch_err  out  1  sticky misaligned-PC flag.

Behaviour:
- States: REQ, WAIT, DROP. At most one outstanding fetch.
- Reset (sync, overrides all): state=REQ, if_valid=0, if_instr=FLUSH_INSTR, if_pc=0, if_pc4=4, fetch_err=0. imem_req=0 and pc_en=0 during the reset cycle. imem_rvalid arriving outside WAIT/DROP is ignored.
- Buffer drain: if_valid && !id_stall clears if_valid at the edge.
- can_issue = !if_valid || !id_stall.
- REQ:
  - imem_req = can_issue && !misaligned && !reset.
  - misaligned = ALIGN_CHECK && PC[1:0]!=0. If misaligned, no request; fetch_err<=1 (sticky until reset); state stays REQ. A redirect to an aligned PC resumes fetching.
  - gnt && !redirect -> WAIT; latch PC into the pending-address register.
  - gnt && redirect -> DROP.
  - No gnt: stay REQ. imem_addr tracks PC, so a redirect updates the address.
- WAIT: buffer is guaranteed empty.
  - rvalid && !redirect: if_instr<=rdata; if_pc<=pending addr; if_pc4<=pending+4; if_valid<=1; pc_en=1 that cycle; -> REQ.
  - rvalid && redirect: discard data, pc_en=0, -> REQ.
  - !rvalid && redirect: -> DROP.
- DROP: rvalid -> discard, -> REQ. Further redirects keep DROP. pc_en=0 throughout.
- Redirect in any state: if_valid<=0 at that edge (flush), overriding buffer load and drain.
- Simultaneous drain and new request in REQ is legal; the buffer is empty by the next edge.
- Throughput: best case one instruction per 2 cycles (gnt cycle t, rvalid t+1, if_valid at t+2).
- pc_en is combinational from state/imem_rvalid/redirect; it is never asserted in REQ or DROP.

Test Plan:
1. Reset, then PC=0x3000, gnt same cycle, rvalid+rdata=0x2408000A next cycle, id_stall=0 -> imem_addr=0x3000, pc_en pulse 1 cycle, if_valid=1, if_instr=0x2408000A, if_pc=0x3000, if_pc4=0x3004.
2. if_valid=1 with id_stall=1 held 3 cycles -> imem_req=0 throughout, buffer unchanged; id_stall=0 -> same-cycle imem_req=1 for the next PC.
3. gnt at t, redirect at t+1 without rvalid, rvalid at t+3 -> DROP, response discarded, pc_en never asserted, next request uses the redirect target 0x3040.
4. redirect in the same cycle as rvalid while if_valid=1 -> if_valid=0 next edge, data dropped, state REQ, pc_en=0.
5. PC=0x3002 -> no imem_req, fetch_err=1 sticky; redirect to 0x3008 -> fetch resumes, fetch_err stays 1 until reset.
6. reset asserted in WAIT -> next cycle all outputs at reset values, state REQ, late rvalid ignored.
